// File: rtl/fp_add_sequencer.sv
// Valid/ready wrapper around the fixed-latency fp_adder: registers operands onto the adder,
// tracks each op with a tagged valid shift register and buffers results in a credit-checked FIFO.
module fp_add_sequencer #(
    parameter int N     = 16,
    parameter int LAT   = 3,
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    input  logic [N-1:0]     add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = N + TAG_W;

    logic [N-1:0]            r_add_a;
    logic [N-1:0]            r_add_b;
    logic [LAT:0]            r_vsr_v;
    logic [LAT:0][TAG_W-1:0] r_vsr_tag;
    logic [ENT_W-1:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_fifo_cnt;
    logic [CNT_W-1:0]        r_outst;
    logic                    r_out_valid;
    logic [N-1:0]            r_out_data;
    logic [TAG_W-1:0]        r_out_tag;

    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic [PTR_W-1:0]        w_rd_nxt;
    logic [CNT_W-1:0]        w_cnt_left;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits come from the registered count only, so a pop frees a slot one cycle later.
    assign in_ready   = rst_n & (r_outst < CNT_W'(DEPTH));
    assign w_accept   = in_valid & in_ready;
    assign w_push     = r_vsr_v[LAT];
    assign w_pop      = r_out_valid & out_ready;
    assign w_rd_nxt   = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    assign w_cnt_left = r_fifo_cnt - CNT_W'(w_pop);

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_vsr_v   <= '0;
            r_vsr_tag <= '0;
        end else begin
            r_add_a   <= w_accept ? in_a : '0;
            r_add_b   <= w_accept ? in_b : '0;
            r_vsr_v   <= {r_vsr_v[LAT-1:0], w_accept};
            r_vsr_tag <= {r_vsr_tag[LAT-1:0], (w_accept ? in_tag : {TAG_W{1'b0}})};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {add_result, r_vsr_tag[LAT]};
    end

    // Head register shows the entry left after this edge's pop; a fresh push appears one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_outst     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            r_rd_ptr    <= w_rd_nxt;
            r_fifo_cnt  <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            r_outst     <= r_outst + CNT_W'(w_accept) - CNT_W'(w_pop);
            r_out_valid <= (w_cnt_left != '0);
            if (w_cnt_left != '0)
                {r_out_data, r_out_tag} <= r_mem[w_rd_nxt];
        end
    end

    always @(posedge clk) begin
        if (rst_n)
            assert (!(w_push && !w_pop && (r_fifo_cnt == CNT_W'(DEPTH))))
                else $error("fp_add_sequencer: result pushed into a full FIFO");
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer with a behavioural 3-cycle half-precision adder
// and a golden fp16 add computed through real arithmetic.
module tb_fp_add_sequencer;
    localparam int N     = 16;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic [N-1:0]     add_result;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    fp_add_sequencer #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    // ---------------- golden half-precision arithmetic ----------------
    function automatic real pow2(input int k);
        real p;
        p = 1.0;
        if (k >= 0) repeat (k) p = p * 2.0;
        else        repeat (-k) p = p / 2.0;
        return p;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:10]);
        if (e == 0) m = real'(int'(h[9:0])) * pow2(-24);
        else        m = real'(1024 + int'(h[9:0])) * pow2(e - 25);
        return h[15] ? -m : m;
    endfunction

    function automatic real rne(input real x);
        real fl, fr;
        fl = $floor(x);
        fr = x - fl;
        if (fr > 0.5) return fl + 1.0;
        if (fr < 0.5) return fl;
        return ((fl / 2.0) == $floor(fl / 2.0)) ? fl : fl + 1.0;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        logic s;
        real  mag, p;
        int   e, m;
        s   = (x < 0.0);
        mag = s ? -x : x;
        if (mag < pow2(-14)) begin
            m = int'(rne(mag * pow2(24)));
            return {s, 15'(m)};
        end
        e = -14;
        p = pow2(-14);
        while (mag >= 2.0 * p && e < 16) begin
            p = p * 2.0;
            e++;
        end
        m = int'(rne(mag / p * 1024.0));
        if (m == 2048) begin
            m = 1024;
            e++;
        end
        if (e > 15) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(m - 1024)};
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] rand_fp();
        return {1'($urandom), 5'($urandom_range(29, 1)), 10'($urandom)};
    endfunction

    // ---------------- behavioural fp_adder: samples at e+1, result after e+LAT ----------------
    logic [N-1:0] s1_a, s1_b, s2_sum, s3_sum;
    always @(posedge clk) begin
        s1_a   <= add_a;
        s1_b   <= add_b;
        s2_sum <= fp_add(s1_a, s1_b);
        s3_sum <= s2_sum;
    end
    assign add_result = s3_sum;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [N-1:0]     d;
        logic [TAG_W-1:0] t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_pops = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Inputs only change 1 time unit after a rising edge, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)
            exp_q.push_back({fp_add(in_a, in_b), in_tag});
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output_queue_size", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.d));
                chk("out_tag", 32'(out_tag), 32'(mon_e.t));
            end
            n_pops++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic single_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] tag, input logic [15:0] sum);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = 1'b1;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 5) chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
            if (k == 5) begin
                chk({nm, "_valid"}, 32'(out_valid), 32'd1);
                chk({nm, "_data"}, 32'(out_data), 32'(sum));
                chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
            end
            if (k == 6) chk({nm, "_valid_after_pop"}, 32'(out_valid), 32'd0);
        end
    endtask

    logic [15:0] arr_a [10];
    logic [15:0] arr_b [10];
    logic [15:0] ra, rb;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, p0;
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;

        // Reset
        #23;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Single op: 1.0 + 1.0 = 2.0
        single_op("single", 16'h3C00, 16'h3C00, 4'h2, 16'h4000);

        // Backpressure
        for (int i = 0; i < 10; i++) begin
            arr_a[i] = rand_fp();
            arr_b[i] = rand_fp();
        end
        out_ready = 1'b0;
        t = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (t < 10);
            in_tag   = 4'(t);
            in_a     = arr_a[t];
            in_b     = arr_b[t];
            acc      = in_valid && in_ready;
            tick();
            if (acc) t++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(t), 32'd8);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        tick(); tick(); tick();
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_tag", 32'(out_tag), 32'd0);
        chk("bp_hold_data", 32'(out_data), 32'(fp_add(arr_a[0], arr_b[0])));
        p0 = n_pops;
        out_ready = 1'b1;
        chk("bp_pop_cycle_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
        drain("bp_drain", 40);
        chk("bp_pop_count", 32'(n_pops - p0), 32'd8);

        // Streaming
        p0 = n_pops;
        out_ready = 1'b1;
        for (int k = 0; k < 26; k++) begin
            in_valid = (k < 20);
            in_a     = rand_fp();
            in_b     = rand_fp();
            in_tag   = 4'(k);
            if (k < 20) chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("stream_out_valid", 32'(out_valid), 32'((k >= 5) && (k <= 24)));
        end
        in_valid = 1'b0;
        drain("stream_drain", 20);
        chk("stream_pop_count", 32'(n_pops - p0), 32'd20);

        // Full edge
        p0 = n_pops;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_a     = rand_fp();
            in_b     = rand_fp();
            in_tag   = 4'(k + 3);
            chk("full_fill_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("full_in_ready_low", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = rand_fp();
        in_b      = rand_fp();
        in_tag    = 4'hF;
        chk("full_pop_cycle_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("full_next_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("full_refilled_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        drain("full_drain", 40);
        chk("full_pop_count", 32'(n_pops - p0), 32'd9);

        // Reset mid-op: ops 0,1 in the FIFO, ops 2..4 in the valid shift register
        p0 = n_pops;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a     = rand_fp();
            in_b     = rand_fp();
            in_tag   = 4'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        #9;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("midrst_quiet", 32'(out_valid), 32'd0);
        end
        chk("midrst_no_pops", 32'(n_pops - p0), 32'd0);
        ra = rand_fp();
        rb = rand_fp();
        single_op("post_rst", ra, rb, 4'h9, fp_add(ra, rb));
        drain("final_drain", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
